// File: rtl/xcel_mem_arbiter.sv
// Round-robin arbiter that shares one 16B memory port between a processor (port 0)
// and an accelerator (port 1); an in-order ID FIFO steers responses back to the issuer.
package xcel_mem_pkg;
    typedef struct packed {
        logic [3:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [3:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;
endpackage

module xcel_mem_arbiter
    import xcel_mem_pkg::*;
#(
    parameter int p_num_inflight = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  mem_req_16B_t  req0_msg,
    input  logic          req0_val,
    output logic          req0_rdy,
    output mem_resp_16B_t resp0_msg,
    output logic          resp0_val,
    input  logic          resp0_rdy,

    input  mem_req_16B_t  req1_msg,
    input  logic          req1_val,
    output logic          req1_rdy,
    output mem_resp_16B_t resp1_msg,
    output logic          resp1_val,
    input  logic          resp1_rdy,

    output mem_req_16B_t  mem_reqstream_msg,
    output logic          mem_reqstream_val,
    input  logic          mem_reqstream_rdy,

    input  mem_resp_16B_t mem_respstream_msg,
    input  logic          mem_respstream_val,
    output logic          mem_respstream_rdy
);
    localparam int c_ptr_w = $clog2(p_num_inflight);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(p_num_inflight);

    logic                      prio_q, prio_d;
    logic [p_num_inflight-1:0] ids_q, ids_d;
    logic [c_ptr_w-1:0]        wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]        rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]        count_q, count_d;

    logic grant, can_issue, req_fire, resp_fire, resp_active, head_id;

    // Request side looks only at count_q, so a same-cycle pop never frees a slot early.
    always_comb begin
        grant             = (req0_val & req1_val) ? prio_q : req1_val;
        can_issue         = ~reset & (count_q < c_full);
        mem_reqstream_val = can_issue & (req0_val | req1_val);
        mem_reqstream_msg = '0;
        if (mem_reqstream_val) begin
            mem_reqstream_msg = grant ? req1_msg : req0_msg;
        end
        req0_rdy = can_issue & mem_reqstream_rdy & ~grant;
        req1_rdy = can_issue & mem_reqstream_rdy & grant;
        req_fire = mem_reqstream_val & mem_reqstream_rdy;
    end

    // Responses are steered by the oldest outstanding ID; with none outstanding, hold them off.
    always_comb begin
        head_id            = ids_q[rd_ptr_q];
        resp_active        = ~reset & (count_q != '0);
        resp0_val          = resp_active & ~head_id & mem_respstream_val;
        resp1_val          = resp_active & head_id & mem_respstream_val;
        resp0_msg          = resp0_val ? mem_respstream_msg : '0;
        resp1_msg          = resp1_val ? mem_respstream_msg : '0;
        mem_respstream_rdy = resp_active & (head_id ? resp1_rdy : resp0_rdy);
        resp_fire          = mem_respstream_val & mem_respstream_rdy;
    end

    always_comb begin
        prio_d   = prio_q;
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (req_fire) begin
            prio_d          = ~grant;
            ids_d[wr_ptr_q] = grant;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (resp_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({req_fire, resp_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q   <= 1'b0;
            ids_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            prio_q   <= prio_d;
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: doc/xcel_mem_arbiter.md
Name: xcel_mem_arbiter

Overview:
- Shares one 16B memory request/response port between two requesters: port 0 (processor data port) and port 1 (accelerator memory port).
- Round-robin arbitration on requests.
- Responses return in order; an in-order ID FIFO routes each one to the requester that issued the matching request.
- Sits between the processor/accelerator pair and the single cache/memory interface in the composed tile.

Parameters:
p_num_inflight, 4, max outstanding memory requests (ID FIFO depth); power of two, >= 2

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req0_msg  input  $bits(mem_req_16B_t)  requester 0 memory request
req0_val  input  1  requester 0 request valid
req0_rdy  output  1  requester 0 request ready
resp0_msg  output  $bits(mem_resp_16B_t)  response to requester 0
resp0_val  output  1  response 0 valid
resp0_rdy  input  1  response 0 ready
req1_msg  input  $bits(mem_req_16B_t)  requester 1 memory request
req1_val  input  1  requester 1 request valid
req1_rdy  output  1  requester 1 request ready
resp1_msg  output  $bits(mem_resp_16B_t)  response to requester 1
resp1_val  output  1  response 1 valid
resp1_rdy  input  1  response 1 ready
mem_reqstream_msg  output  $bits(mem_req_16B_t)  request to memory
mem_reqstream_val  output  1  memory request valid
mem_reqstream_rdy  input  1  memory request ready
mem_respstream_msg  input  $bits(mem_resp_16B_t)  memory response
mem_respstream_val  input  1  memory response valid
mem_respstream_rdy  output  1  memory response ready

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- State:
  - prio_reg (1 bit): 0 = requester 0 has priority.
  - ID FIFO: p_num_inflight entries of 1-bit requester ID, with count register.
  - All state is reset to prio_reg=0, FIFO empty, count=0.
- Outputs during reset: all val/rdy outputs are 0 in the cycle after reset asserts.
- Forced-zero messages: all message outputs are forced to zero whenever their val is 0.
- Arbitration (combinational, zero added latency):
  - can_issue = (count < p_num_inflight).
  - Only req0_val: grant 0. Only req1_val: grant 1. Both: grant the prio_reg requester.
- Request handshake:
  - mem_reqstream_val = can_issue & (req0_val | req1_val).
  - mem_reqstream_msg = granted request, passed unmodified, opaque included.
  - reqN_rdy = can_issue & mem_reqstream_rdy & (grant == N); the non-granted requester sees rdy=0.
  - mem_reqstream_val never depends on mem_reqstream_rdy.
- On request fire (val & rdy):
  - Push grant ID into FIFO.
  - prio_reg <= ~grant. Priority flips only on a fire, never on a stall.
- Response routing:
  - FIFO empty: mem_respstream_rdy=0 and both resp vals are 0. Unexpected responses are back-pressured, never dropped.
  - FIFO non-empty, head=h: respH_val = mem_respstream_val, respH_msg = mem_respstream_msg unmodified, mem_respstream_rdy = respH_rdy. The other response port has val 0.
  - Pop FIFO on mem response fire.
- Full FIFO: count==p_num_inflight blocks new requests even if a pop occurs that cycle. There is no comb path from the response side to the request side.
- Simultaneous push and pop: count is unchanged, pointers both advance, wrap modulo p_num_inflight.
- Count width: $clog2(p_num_inflight)+1 bits; no overflow or underflow is reachable.
- Reset mid-operation: in-flight IDs are discarded; memory and requesters are reset together by the system.
- Line trace (non-synthesis): grant ID and count.

Test Plan:
- Single requester 0: 4 reads to 0x1000..0x100C, memory returns 0xA,0xB,0xC,0xD -> resp0 gets them in order; resp1_val never 1; mem req msgs bit-identical to inputs.
- Both valid every cycle, mem always ready -> grants alternate 0,1,0,1 starting with 0 after reset; each response lands on its issuer.
- Memory responds with 10-cycle latency, p_num_inflight=4, req1 streaming -> exactly 4 requests issue, req1_rdy=0 until the first response fires; no 5th request in the pop cycle.
- Response back-pressure: head ID=1, resp1_rdy=0 for 3 cycles -> mem_respstream_rdy=0 for those cycles, response held, delivered on cycle 4; FIFO count unchanged until then.
- Stall fairness: both valid, mem_reqstream_rdy=0 for 5 cycles -> prio_reg unchanged, grant stays 0; first fire goes to 0, next to 1.
- Reset asserted with 3 in flight -> next cycle all vals and rdys 0, count=0; spurious mem response is back-pressured (rdy=0).
